// File: rtl/demux_8_1_buffered_if.sv
// Handshake bundle for demux_8_1_buffered: one routed input stream and two
// buffered output ports (A selected by S=1, B by S=0).
interface demux_8_1_buffered_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] in_value;
   logic             in_valid;
   logic             S;
   logic             in_ready;

   logic [WIDTH-1:0] A_value;
   logic             A_valid;
   logic             A_ready;
   logic [CW-1:0]    A_count;

   logic [WIDTH-1:0] B_value;
   logic             B_valid;
   logic             B_ready;
   logic [CW-1:0]    B_count;

   modport master (
      output in_value, in_valid, S, A_ready, B_ready,
      input  in_ready, A_value, A_valid, A_count, B_value, B_valid, B_count
   );

   modport slave (
      input  in_value, in_valid, S, A_ready, B_ready,
      output in_ready, A_value, A_valid, A_count, B_value, B_valid, B_count
   );
endinterface

// File: rtl/demux_8_1_buffered.sv
// Buffered 1-to-2 byte demultiplexer: S steers each accepted byte into the A
// (S=1) or B (S=0) FIFO; each FIFO drains through its own valid/ready port.
module demux_8_1_buffered #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input logic                 clk,
   input logic                 reset,
   demux_8_1_buffered_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // Index 0 is port A, index 1 is port B.
   logic [WIDTH-1:0] mem_r    [2][DEPTH];
   logic [PW-1:0]    wr_ptr_r [2];
   logic [PW-1:0]    rd_ptr_r [2];
   logic [CW-1:0]    count_r  [2];
   logic             push_s   [2];
   logic             pop_s    [2];
   logic             ready_s;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == LAST_PTR) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Fullness is judged on the registered count only, so a same-cycle pop never frees a slot.
   always_comb begin
      ready_s   = bus.S ? (count_r[0] < FULL_CNT) : (count_r[1] < FULL_CNT);
      push_s[0] = bus.in_valid & ready_s & bus.S;
      push_s[1] = bus.in_valid & ready_s & ~bus.S;
      pop_s[0]  = (count_r[0] != {CW{1'b0}}) & bus.A_ready;
      pop_s[1]  = (count_r[1] != {CW{1'b0}}) & bus.B_ready;
   end

   assign bus.in_ready = ready_s;
   assign bus.A_valid  = (count_r[0] != {CW{1'b0}});
   assign bus.B_valid  = (count_r[1] != {CW{1'b0}});
   assign bus.A_value  = bus.A_valid ? mem_r[0][rd_ptr_r[0]] : {WIDTH{1'b0}};
   assign bus.B_value  = bus.B_valid ? mem_r[1][rd_ptr_r[1]] : {WIDTH{1'b0}};
   assign bus.A_count  = count_r[0];
   assign bus.B_count  = count_r[1];

   // Pointer and occupancy state for both FIFOs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            wr_ptr_r[p] <= {PW{1'b0}};
            rd_ptr_r[p] <= {PW{1'b0}};
            count_r[p]  <= {CW{1'b0}};
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
               wr_ptr_r[p] <= ptr_next(wr_ptr_r[p]);
            end else begin
               wr_ptr_r[p] <= wr_ptr_r[p];
            end
            if (pop_s[p]) begin
               rd_ptr_r[p] <= ptr_next(rd_ptr_r[p]);
            end else begin
               rd_ptr_r[p] <= rd_ptr_r[p];
            end
            case ({push_s[p], pop_s[p]})
               2'b10:   count_r[p] <= count_r[p] + CW'(1);
               2'b01:   count_r[p] <= count_r[p] - CW'(1);
               default: count_r[p] <= count_r[p];
            endcase
         end
      end
   end

   // Storage needs no reset: a slot is only visible once its count covers it.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (!reset && push_s[p]) begin
            mem_r[p][wr_ptr_r[p]] <= bus.in_value;
         end
      end
   end
endmodule

// File: tb/tb_demux_8_1_buffered.sv
// Self-checking bench for demux_8_1_buffered: a DEPTH=2 and a DEPTH=3 instance,
// each shadowed by a queue scoreboard checked every cycle plus directed checks.
module tb_demux_8_1_buffered;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   logic [7:0] q [4][$];

   demux_8_1_buffered_if #(.WIDTH(8), .DEPTH(2)) i2 ();
   demux_8_1_buffered_if #(.WIDTH(8), .DEPTH(3)) i3 ();

   demux_8_1_buffered #(.WIDTH(8), .DEPTH(2)) d2 (.clk(clk), .reset(reset), .bus(i2));
   demux_8_1_buffered #(.WIDTH(8), .DEPTH(3)) d3 (.clk(clk), .reset(reset), .bus(i3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare one DUT against its queues, then apply this cycle's push/pop/reset to the queues.
   task automatic check_dut(input int d, input int depth,
                            input logic rdy, input logic av, input logic [7:0] aval, input logic [1:0] acnt,
                            input logic bv, input logic [7:0] bval, input logic [1:0] bcnt,
                            input logic s, input logic iv, input logic [7:0] ival,
                            input logic ar, input logic br);
      int   qa;
      int   qb;
      logic exp_rdy;
      qa = 2 * d;
      qb = 2 * d + 1;
      exp_rdy = s ? (q[qa].size() < depth) : (q[qb].size() < depth);
      chk($sformatf("d%0d_in_ready", d), {31'd0, rdy}, {31'd0, exp_rdy});
      chk($sformatf("d%0d_A_count", d), {30'd0, acnt}, q[qa].size());
      chk($sformatf("d%0d_B_count", d), {30'd0, bcnt}, q[qb].size());
      chk($sformatf("d%0d_A_valid", d), {31'd0, av}, (q[qa].size() > 0) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d_B_valid", d), {31'd0, bv}, (q[qb].size() > 0) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d_A_value", d), {24'd0, aval}, (q[qa].size() > 0) ? {24'd0, q[qa][0]} : 32'd0);
      chk($sformatf("d%0d_B_value", d), {24'd0, bval}, (q[qb].size() > 0) ? {24'd0, q[qb][0]} : 32'd0);
      if (reset) begin
         q[qa].delete();
         q[qb].delete();
      end else begin
         if (ar && q[qa].size() > 0) void'(q[qa].pop_front());
         if (br && q[qb].size() > 0) void'(q[qb].pop_front());
         if (iv && exp_rdy) begin
            if (s) q[qa].push_back(ival);
            else   q[qb].push_back(ival);
         end
      end
   endtask

   // One clock: check both DUTs mid-cycle, then advance to just after the next rising edge.
   task automatic cycle();
      @(negedge clk);
      check_dut(0, 2, i2.in_ready, i2.A_valid, i2.A_value, i2.A_count, i2.B_valid, i2.B_value, i2.B_count,
                i2.S, i2.in_valid, i2.in_value, i2.A_ready, i2.B_ready);
      check_dut(1, 3, i3.in_ready, i3.A_valid, i3.A_value, i3.A_count, i3.B_valid, i3.B_value, i3.B_count,
                i3.S, i3.in_valid, i3.in_value, i3.A_ready, i3.B_ready);
      @(posedge clk);
      #1;
   endtask

   task automatic set2(input logic iv, input logic s, input logic [7:0] v, input logic ar, input logic br);
      i2.in_valid = iv; i2.S = s; i2.in_value = v; i2.A_ready = ar; i2.B_ready = br;
   endtask

   task automatic set3(input logic iv, input logic s, input logic [7:0] v, input logic ar, input logic br);
      i3.in_valid = iv; i3.S = s; i3.in_value = v; i3.A_ready = ar; i3.B_ready = br;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      set2(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
      set3(1'b1, 1'b0, 8'h5B, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      set2(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      set3(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      #1;
      chk("reset_A_count", {30'd0, i2.A_count}, 32'd0);
      chk("reset_A_valid", {31'd0, i2.A_valid}, 32'd0);
      chk("reset_in_ready", {31'd0, i2.in_ready}, 32'd1);
      cycle();

      // Basic route
      set2(1'b1, 1'b1, 8'b01100101, 1'b0, 1'b0); cycle();
      set2(1'b1, 1'b0, 8'b10101100, 1'b0, 1'b0); cycle();
      set2(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("basic_A_value", {24'd0, i2.A_value}, 32'h65);
      chk("basic_A_count", {30'd0, i2.A_count}, 32'd1);
      chk("basic_B_value", {24'd0, i2.B_value}, 32'hAC);
      chk("basic_B_count", {30'd0, i2.B_count}, 32'd1);
      cycle();
      set2(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); cycle();
      chk("basic_pop_A_valid", {31'd0, i2.A_valid}, 32'd0);
      chk("basic_pop_A_value", {24'd0, i2.A_value}, 32'd0);
      set2(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cycle();
      set2(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); cycle();

      // Full and backpressure
      set2(1'b1, 1'b1, 8'h11, 1'b0, 1'b0); cycle();
      set2(1'b1, 1'b1, 8'h22, 1'b0, 1'b0); cycle();
      set2(1'b1, 1'b1, 8'h33, 1'b0, 1'b0); #1;
      chk("full_in_ready", {31'd0, i2.in_ready}, 32'd0);
      cycle();
      chk("full_A_count", {30'd0, i2.A_count}, 32'd2);
      chk("full_head", {24'd0, i2.A_value}, 32'h11);
      set2(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); #1;
      chk("full_switch_B_ready", {31'd0, i2.in_ready}, 32'd1);
      cycle();

      // Full with simultaneous pop
      set2(1'b1, 1'b1, 8'h44, 1'b1, 1'b0); #1;
      chk("fullpop_in_ready", {31'd0, i2.in_ready}, 32'd0);
      cycle();
      chk("fullpop_A_count", {30'd0, i2.A_count}, 32'd1);
      chk("fullpop_head", {24'd0, i2.A_value}, 32'h22);
      set2(1'b1, 1'b1, 8'h44, 1'b0, 1'b0); cycle();
      chk("fullpop_accept", {30'd0, i2.A_count}, 32'd2);
      set2(1'b0, 1'b1, 8'h00, 1'b1, 1'b0); cycle(); cycle();
      set2(1'b0, 1'b1, 8'h00, 1'b0, 1'b0); cycle();

      // Wraparound on DEPTH=3 with continuous drain
      for (int k = 1; k <= 10; k++) begin
         set3(1'b1, 1'b1, 8'(k), 1'b1, 1'b0);
         cycle();
         chk($sformatf("wrap_count_%0d", k), {30'd0, i3.A_count}, 32'd1);
         chk($sformatf("wrap_value_%0d", k), {24'd0, i3.A_value}, k);
      end
      set3(1'b0, 1'b1, 8'h00, 1'b1, 1'b0); cycle();
      set3(1'b0, 1'b1, 8'h00, 1'b0, 1'b0); cycle();

      // Reset mid-operation
      set2(1'b1, 1'b1, 8'h51, 1'b0, 1'b0); cycle();
      set2(1'b1, 1'b1, 8'h52, 1'b0, 1'b0); cycle();
      set2(1'b1, 1'b0, 8'h53, 1'b0, 1'b0); cycle();
      chk("prerst_A_count", {30'd0, i2.A_count}, 32'd2);
      chk("prerst_B_count", {30'd0, i2.B_count}, 32'd1);
      reset = 1'b1;
      set2(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0); cycle();
      reset = 1'b0;
      set2(1'b0, 1'b1, 8'h00, 1'b0, 1'b0); #1;
      chk("rst_A_count", {30'd0, i2.A_count}, 32'd0);
      chk("rst_B_count", {30'd0, i2.B_count}, 32'd0);
      chk("rst_A_valid", {31'd0, i2.A_valid}, 32'd0);
      chk("rst_B_valid", {31'd0, i2.B_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, i2.in_ready}, 32'd1);
      cycle(); cycle();

      // Interleaved traffic
      for (int i = 0; i < 8; i++) begin
         set2(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b1);
         #1;
         chk($sformatf("ilv_ready_%0d", i), {31'd0, i2.in_ready}, (i % 2 == 0 && i >= 4) ? 32'd0 : 32'd1);
         cycle();
      end
      set2(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); cycle();
      chk("ilv_A_head", {24'd0, i2.A_value}, 32'hA0);
      chk("ilv_A_count", {30'd0, i2.A_count}, 32'd2);
      set2(1'b0, 1'b1, 8'h00, 1'b1, 1'b0); cycle();
      chk("ilv_A_second", {24'd0, i2.A_value}, 32'hA2);
      cycle();
      set2(1'b0, 1'b1, 8'h00, 1'b0, 1'b0); cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/demux_8_1_buffered.md
# demux_8_1_buffered

Buffered 1-to-2 byte demultiplexer: the receiving end of the `MUX_8_1` select convention. One 8-bit input stream is steered by select `S` to output port A (`S`=1) or port B (`S`=0). Each port has its own small FIFO and a valid/ready handshake, so a stalled consumer on one port never corrupts or reorders data on the other. It sits between the emulator's shared byte bus and the two downstream consumers that previously sat on the inputs of a `MUX_8_1`.

## Interface
- `WIDTH`, 8: data width of input and both outputs.
- `DEPTH`, 2: entries per output FIFO; any integer ≥1, not restricted to powers of two.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; takes effect on the rising edge where it is sampled high.
- `in_value` input WIDTH: byte to route.
- `in_valid` input 1: `in_value` and `S` are valid this cycle.
- `S` input 1: 1 routes to A, 0 routes to B. Same polarity as `MUX_8_1`.
- `in_ready` output 1: the FIFO selected by the current `S` can accept a byte.
- `A_value` output WIDTH: head of the A FIFO; 0 when `A_valid`=0.
- `A_valid` output 1: the A FIFO is non-empty.
- `A_ready` input 1: the A consumer accepts the head this cycle.
- `A_count` output clog2(DEPTH+1): number of A entries.
- `B_value`, `B_valid`, `B_ready`, `B_count`: as for A, applied to the B FIFO.

## Operation
- Push: when `in_valid` and `in_ready` are both high at a rising edge, `in_value` is written to the tail of the FIFO chosen by `S`. That FIFO's count increments by 1.
- `in_ready` is combinational:
  - 1 when the count of the selected FIFO is less than DEPTH.
  - It ignores any pop of that FIFO in the same cycle, so a full FIFO never accepts a push, even while it is popping.
  - It ignores `in_valid`, and is valid for the current `S` even when `in_valid`=0.
- Pop: when `X_valid` and `X_ready` are both high at a rising edge, the FIFO X head advances and its count decrements by 1.
- `X_ready` has no effect while `X_valid`=0.
- Simultaneous push and pop on the same FIFO (count between 1 and DEPTH−1): the count is unchanged and both pointers advance. Data order is preserved.
- Simultaneous push to one FIFO and pop from the other: the two operations are independent.
- Pointers are explicit modulo-DEPTH counters that wrap from DEPTH−1 to 0. Wrap must be correct for non-power-of-two DEPTH.
- Ordering: bytes leave each port in the order they were accepted. There is no ordering relation between A and B.
- When `in_valid`=0, no push occurs regardless of `S`.
- No data is ever dropped. An upstream that presents `in_valid` without `in_ready` must hold its value; this module does not latch it.
- Reset:
  - Both counts go to 0 and all pointers go to 0.
  - `A_valid`, `B_valid`, `A_value`, `B_value`, `A_count` and `B_count` all become 0.
  - `in_ready`=1, since the FIFO selected by `S` is empty.
  - Any push or pop requested in the reset cycle is ignored.
  - Reset mid-stream discards all buffered bytes.

## Timing
- Latency from input to output is 1 cycle. A byte accepted at edge N gives `X_valid`=1 with that byte on `X_value` after edge N.
- No combinational path from `in_value`/`in_valid` to any output port.
- The only combinational paths are:
  - `S` → `in_ready`.
  - `X_value` and `X_valid` from FIFO state only (registered).
- Throughput: one push per cycle sustained while the selected FIFO is not full and its consumer pops every cycle.
- FIFO state after the edge following reset is all-empty, independent of inputs during reset.

## Test plan
- Basic route: `S`=1 with `in_value`=8'b01100101 for one cycle, then `S`=0 with 8'b10101100, all readies 0.
  - Required: `A_value`=01100101 with `A_count`=1, and `B_value`=10101100 with `B_count`=1.
  - Then `A_ready`=1 for one cycle gives `A_valid`=0 and `A_value`=0.
- Full and backpressure: DEPTH=2, push 0x11, 0x22, 0x33 to A with `A_ready`=0.
  - Required: `in_ready` drops after the second push, and 0x33 is not accepted.
  - Switching to `S`=0 gives `in_ready`=1 at once.
  - Draining A yields 0x11 then 0x22.
- Full with simultaneous pop: A full and `A_ready`=1 while pushing 0x44.
  - Required: the push is rejected (`in_ready`=0) and `A_count` goes 2→1.
  - The next cycle accepts 0x44.
- Wraparound: DEPTH=3, with `A_ready`=1 throughout, stream 0x01..0x0A into A one per cycle.
  - Required: the output sequence is 0x01..0x0A, no gaps after the first, and `A_count` stays at 1.
- Reset mid-operation: A holds 2 entries and B holds 1, then assert `reset` for one cycle with `in_valid`=1.
  - Required: both counts are 0, both valids are 0, and `in_ready`=1 after the edge.
  - No byte from the reset cycle appears on either port.
- Interleaved traffic: alternate `S` every cycle pushing 0xA0..0xA7, with `B_ready`=1 and `A_ready`=0.
  - Required: B emits 0xA1, 0xA3, … in order.
  - A holds 0xA0, 0xA2 and then blocks (`in_ready`=0 only when `S`=1).
